// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and constants for the pmem memory block.
//   pmem_state_e : controller state (zero-fill vs normal service)
//   LATENCY_MIN/LATENCY_MAX : legal read-latency range
//   byte_lanes() : number of byte write-enable lanes for a word width
package pmem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } pmem_state_e;

  localparam int LATENCY_MIN = 32'sd1;
  localparam int LATENCY_MAX = 32'sd4;

  // One write-enable lane per 8-bit byte of the word.
  function automatic int byte_lanes(input int data_w);
    return data_w / 32'sd8;
  endfunction

endpackage

// File: rtl/pmem_ram.sv
// pmem_ram: DEPTH x DATA_W single-port storage array with per-byte write
// enables and a registered read port (block-RAM style).
//   clock, reset : clock; reset only clears the read output register
//   we, be       : word write enable and byte-lane enables
//   addr, wdata  : shared address and write data
//   re           : read enable; rdata updates one edge later, holds otherwise
//   rdata        : registered read data
module pmem_ram
  import pmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          we,
  input  logic [byte_lanes(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          re,
  output logic [DATA_W-1:0]             rdata
);

  localparam int NBE   = byte_lanes(DATA_W);
  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < NBE; i++) begin
        if (be[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/pmem.sv
// pmem: parametrised single-port synchronous memory with request/response
// handshake, byte-lane write strobes, configurable read latency and a
// built-in zero-fill engine.
//   clock, reset          : rising-edge clock, async active-high reset
//   req_valid/req_ready   : request handshake (ready only while not filling)
//   req_wren, req_addr    : 1 = write / 0 = read, word address
//   req_wdata, req_be     : write data and byte-lane enables
//   rsp_valid, rsp_rdata  : one-cycle read response pulse and held read data
//   clear_req             : pulse to start a runtime zero-fill
//   busy                  : zero-fill in progress
module pmem
  import pmem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wren,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [byte_lanes(DATA_W)-1:0] req_be,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  input  logic                          clear_req,
  output logic                          busy
);

  localparam int NBE = byte_lanes(DATA_W);
  localparam pmem_state_e ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // Parameter legality, rejected at elaboration.
  if ((DATA_W % 32'sd8) != 32'sd0) begin : g_bad_data_w
    $error("pmem: DATA_W must be a multiple of 8");
  end
  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
    $error("pmem: LATENCY must be within 1..4");
  end

  pmem_state_e       state_r, state_nx_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              accept_s;
  logic              ram_we_s, ram_re_s;
  logic [NBE-1:0]    ram_be_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic              rd_vld_r;

  // Read pipeline taps: stage 0 is the RAM output register, the last
  // stage drives the response outputs.
  logic [LATENCY-1:0]             stg_vld_s;
  logic [LATENCY-1:0][DATA_W-1:0] stg_dat_s;

  // Handshake outputs are straight decodes of the state register.
  assign req_ready = (state_r == ST_RUN);
  assign busy      = (state_r == ST_CLEAR);
  assign accept_s  = req_valid & req_ready;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: the fill ends after the top word is written; a clear
  // request in service starts a new fill on the following cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == {ADDR_W{1'b1}}) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nx_s = ST_CLEAR;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_INIT;
    endcase
  end

  // Fill address counter; wraps to zero on the last fill write and is
  // parked at zero in service so every fill starts at word 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_cnt_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
    end else begin
      clr_cnt_r <= '0;
    end
  end

  // RAM port mux: zero-fill traffic while clearing, requests otherwise.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_be_s    = '0;
    ram_addr_s  = req_addr;
    ram_wdata_s = req_wdata;
    case (state_r)
      ST_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_be_s    = '1;
        ram_addr_s  = clr_cnt_r;
        ram_wdata_s = '0;
      end
      ST_RUN: begin
        ram_we_s = accept_s & req_wren;
        ram_re_s = accept_s & ~req_wren;
        ram_be_s = req_be;
      end
      default: begin
        ram_we_s = 1'b0;
        ram_re_s = 1'b0;
      end
    endcase
  end

  pmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we_s),
    .be    (ram_be_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .rdata (ram_rdata_s)
  );

  // Valid bit matching the RAM read register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_vld_r <= 1'b0;
    end else begin
      rd_vld_r <= ram_re_s;
    end
  end

  assign stg_vld_s[0] = rd_vld_r;
  assign stg_dat_s[0] = ram_rdata_s;

  // Extra delay stages; data only advances with a valid so the final
  // stage holds the last response while idle.
  for (genvar k = 1; k < LATENCY; k++) begin : g_dly
    logic              vld_r;
    logic [DATA_W-1:0] dat_r;

    // One delay stage of the read pipeline.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_r <= 1'b0;
        dat_r <= '0;
      end else begin
        vld_r <= stg_vld_s[k-1];
        if (stg_vld_s[k-1]) begin
          dat_r <= stg_dat_s[k-1];
        end
      end
    end

    assign stg_vld_s[k] = vld_r;
    assign stg_dat_s[k] = dat_r;
  end

  assign rsp_valid = stg_vld_s[LATENCY-1];
  assign rsp_rdata = stg_dat_s[LATENCY-1];

endmodule

// File: tb/tb_pmem.sv
// tb_pmem: directed, table-driven bench for pmem (ADDR_W=6, DATA_W=32,
// LATENCY=2, CLEAR_ON_RESET=1) with hand-written clear and reset sequences.
module tb_pmem;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wren = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clear_req = 1'b0;
  logic              busy;

  int checks = 0;
  int errors = 0;

  pmem #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .LATENCY        (LATENCY),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wren  (req_wren),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clear_req (clear_req),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              vld;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic [DATA_W-1:0] exp;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [3:0] b);
    req_valid = v;
    req_wren  = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = b;
  endtask

  // Called at a negedge with busy high: counts edges until busy drops.
  task automatic count_busy(input string name);
    int n = 0;
    int ready_bad = 0;
    int rsp_seen = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (busy === 1'b1 && req_ready !== 1'b0) ready_bad++;
      if (rsp_valid !== 1'b0) rsp_seen++;
    end
    check({name, "_busy_cycles"}, n, DEPTH);
    check({name, "_ready_while_busy"}, ready_bad, 0);
    check({name, "_rsp_while_busy"}, rsp_seen, 0);
    check({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Single read from idle; response expected LATENCY cycles after accept.
  task automatic do_read(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    drive(1'b1, 1'b0, a, '0, 4'h0);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 4'h0);
    check({name, "_early"}, {31'd0, rsp_valid}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({name, "_data"}, rsp_rdata, exp);
  endtask

  initial begin
    logic [DATA_W-1:0] last;
    vecs[0]  = '{1'b1, 1'b0, 6'h3F, 32'h0,        4'h0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 6'h05, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 6'h05, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b1, 6'h05, 32'h11223344, 4'h5, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 6'h05, 32'h0,        4'h0, 32'hDE22BE44};
    vecs[5]  = '{1'b1, 1'b1, 6'h05, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 6'h05, 32'h0,        4'h0, 32'hDE22BE44};
    vecs[7]  = '{1'b1, 1'b1, 6'h01, 32'h000000A1, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 6'h02, 32'h000000A2, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 6'h03, 32'h000000A3, 4'hF, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 6'h04, 32'h000000A4, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 6'h01, 32'h0,        4'h0, 32'h000000A1};
    vecs[12] = '{1'b1, 1'b0, 6'h02, 32'h0,        4'h0, 32'h000000A2};
    vecs[13] = '{1'b1, 1'b0, 6'h03, 32'h0,        4'h0, 32'h000000A3};
    vecs[14] = '{1'b1, 1'b0, 6'h04, 32'h0,        4'h0, 32'h000000A4};
    vecs[15] = '{1'b0, 1'b0, 6'h01, 32'h0,        4'h0, 32'h0};
    vecs[16] = '{1'b1, 1'b1, 6'h3F, 32'h12345678, 4'h8, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 6'h3F, 32'h0,        4'h0, 32'h12000000};
    vecs[18] = '{1'b1, 1'b0, 6'h10, 32'h0,        4'h0, 32'h00000000};

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    count_busy("init");

    // Table: response for vector i-1 is visible at the negedge after edge i.
    last = '0;
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) drive(vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else drive(1'b0, 1'b0, '0, '0, 4'h0);
      @(posedge clock);
      @(negedge clock);
      if (i > 0) begin
        if (vecs[i-1].vld && !vecs[i-1].wr) begin
          check($sformatf("vec%0d_valid", i-1), {31'd0, rsp_valid}, 32'd1);
          check($sformatf("vec%0d_data", i-1), rsp_rdata, vecs[i-1].exp);
          last = vecs[i-1].exp;
        end else begin
          check($sformatf("vec%0d_novalid", i-1), {31'd0, rsp_valid}, 32'd0);
          check($sformatf("vec%0d_hold", i-1), rsp_rdata, last);
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0);
    @(posedge clock);
    @(negedge clock);

    // clear_req one cycle after a read accept: in-flight read keeps old data.
    drive(1'b1, 1'b0, 6'h05, '0, 4'h0);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 4'h0);
    clear_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear_req = 1'b0;
    check("clr_inflight_valid", {31'd0, rsp_valid}, 32'd1);
    check("clr_inflight_data", rsp_rdata, 32'hDE22BE44);
    check("clr_busy_start", {31'd0, busy}, 32'd1);
    count_busy("clr");
    do_read("clr_rd05", 6'h05, 32'h00000000);
    do_read("clr_rd01", 6'h01, 32'h00000000);

    // Reset with two reads in flight.
    drive(1'b1, 1'b0, 6'h3F, '0, 4'h0);
    @(posedge clock);
    @(negedge clock);
    drive(1'b1, 1'b0, 6'h3F, '0, 4'h0);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 4'h0);
    check("mid_rst_pre_valid", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_busy("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
